// File: rtl/st2bus_pack_pkg.sv
// Shared defaults, derived widths and FSM encoding for the stream-to-bus packer.
package st2bus_pack_pkg;
    localparam int BUS_W_DEF         = 512;
    localparam int ST_DEF            = 8;
    localparam int BYTES_PER_PKT_DEF = 128;
    localparam int LANES_DEF         = BUS_W_DEF / ST_DEF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/st2bus_fifo2.sv
// Two-entry FIFO; entry 0 is always the head so outputs only move on a pop.
module st2bus_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop, do_push;

    always_comb begin
        do_pop  = pop && (cnt_q != 2'd0);
        do_push = push && ((cnt_q != 2'd2) || do_pop);
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        if (do_pop) begin
            e0_d  = e1_q;
            e1_d  = '0;
            cnt_d = cnt_q - 2'd1;
        end
        // Write slot is chosen from the post-pop occupancy so push+pop keeps order.
        if (do_push) begin
            if (cnt_d == 2'd0) e0_d = push_data;
            else               e1_d = push_data;
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = e0_q;
    assign count = cnt_q;
endmodule

// File: rtl/st2bus_pack.sv
// Packs decoded turbo bytes into BUS_W-bit little-endian words with packet framing checks.
// Handshake: a byte moves when st_valid && st_ready, a word when bus_valid && bus_ready.
module st2bus_pack
    import st2bus_pack_pkg::*;
#(
    parameter int BUS_W         = BUS_W_DEF,
    parameter int ST            = ST_DEF,
    parameter int BYTES_PER_PKT = BYTES_PER_PKT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ST-1:0]    st_data,
    input  logic             st_valid,
    input  logic             st_sop,
    input  logic             st_eop,
    output logic             st_ready,
    output logic [BUS_W-1:0] bus_data,
    output logic             bus_valid,
    output logic             bus_last,
    output logic             bus_err,
    input  logic             bus_ready,
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      err_cnt,
    output state_e           state_dbg
);
    localparam int LANES  = BUS_W / ST;
    localparam int LANE_W = cnt_w(LANES);
    localparam int BYTE_W = cnt_w(BYTES_PER_PKT);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_PKT - 1);

    state_e             state_q, state_d;
    logic [BUS_W-1:0]   asm_q, asm_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic               pend_q, pend_d, pend_last_q, pend_last_d, pend_err_q, pend_err_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

    logic               push, push_last, push_err;
    logic [BUS_W-1:0]   push_word, base_word, wr_word;
    logic [LANE_W-1:0]  base_lane;
    logic [BYTE_W-1:0]  base_byte;
    logic               take, end_pkt, bad_end;
    logic [BUS_W+1:0]   fifo_head;
    logic [1:0]         fifo_cnt;
    logic               fifo_pop, fifo_room;

    assign st_ready  = (fifo_cnt != 2'd2);
    assign bus_valid = (fifo_cnt != 2'd0);
    assign fifo_pop  = bus_valid && bus_ready;
    assign fifo_room = (fifo_cnt != 2'd2) || fifo_pop;

    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        lane_d      = lane_q;
        byte_d      = byte_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        pend_err_d  = pend_err_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        push        = 1'b0;
        push_word   = '0;
        push_last   = 1'b0;
        push_err    = 1'b0;
        base_word   = asm_q;
        base_lane   = lane_q;
        base_byte   = byte_q;
        take        = 1'b0;
        wr_word     = '0;
        end_pkt     = 1'b0;
        bad_end     = 1'b0;

        // A finished word parked because two words completed on one byte goes out first.
        if (pend_q && fifo_room) begin
            push      = 1'b1;
            push_word = asm_q;
            push_last = pend_last_q;
            push_err  = pend_err_q;
            pend_d    = 1'b0;
            asm_d     = '0;
            base_word = '0;
            base_lane = '0;
        end

        if (st_valid && st_ready) begin
            if (st_sop) begin
                if (state_q == S_FILL && byte_q != '0 && !push) begin
                    push      = 1'b1;
                    push_word = asm_q;
                    push_last = 1'b1;
                    push_err  = 1'b1;
                end
                take      = 1'b1;
                base_word = '0;
                base_lane = '0;
                base_byte = '0;
            end else begin
                take = (state_q == S_FILL);
            end

            if (take) begin
                wr_word = base_word;
                for (int i = 0; i < LANES; i++) begin
                    if (base_lane == LANE_W'(i)) wr_word[i*ST +: ST] = st_data;
                end
                end_pkt = st_eop || (base_byte == LAST_BYTE);
                bad_end = end_pkt && !(st_eop && (base_byte == LAST_BYTE));
                if (end_pkt || base_lane == LAST_LANE) begin
                    lane_d = '0;
                    if (push) begin
                        pend_d      = 1'b1;
                        pend_last_d = end_pkt;
                        pend_err_d  = bad_end;
                        asm_d       = wr_word;
                    end else begin
                        push      = 1'b1;
                        push_word = wr_word;
                        push_last = end_pkt;
                        push_err  = bad_end;
                        asm_d     = '0;
                    end
                end else begin
                    asm_d  = wr_word;
                    lane_d = base_lane + LANE_W'(1);
                end
                if (end_pkt) begin
                    byte_d  = '0;
                    state_d = st_eop ? S_IDLE : S_DISCARD;
                end else begin
                    byte_d  = base_byte + BYTE_W'(1);
                    state_d = S_FILL;
                end
            end
        end

        if (push && push_last)             pkt_cnt_d = pkt_cnt_q + 16'd1;
        if (push && push_last && push_err) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            asm_q       <= '0;
            lane_q      <= '0;
            byte_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_err_q  <= 1'b0;
            pkt_cnt_q   <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            lane_q      <= lane_d;
            byte_q      <= byte_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            pend_err_q  <= pend_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    st2bus_fifo2 #(.W(BUS_W + 2)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({push_word, push_last, push_err}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    assign {bus_data, bus_last, bus_err} = fifo_head;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign state_dbg = state_q;
endmodule
